// File: rtl/sample_pair_packer.sv
// rtl/sample_pair_packer.sv - packs a one-sample-per-beat stream into {odd, even} pairs
//
// Ports:
//   clk_i, rst_i        single clock, synchronous active-high reset
//   s_ready_o/s_valid_i input handshake; s_sof_i/s_eol_i frame/line markers; s_data_i sample x[n]
//   m_ready_i/m_valid_o output handshake; m_sof_o/m_eol_o first pair of frame / last pair of line
//   m_data_o            {odd, even} = {x[2k+1], x[2k]}
//   err_o               registered one-cycle pulse after a sof arrives while an even sample is held
//
// Odd-length lines are closed with a symmetric-extension pad: {x[N-2], x[N-1]},
// or {x[0], x[0]} for a single-sample line.
module sample_pair_packer #(
    parameter int DataWidth = 16
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    output logic                   s_ready_o,
    input  logic                   s_valid_i,
    input  logic                   s_sof_i,
    input  logic                   s_eol_i,
    input  logic [DataWidth-1:0]   s_data_i,
    input  logic                   m_ready_i,
    output logic                   m_valid_o,
    output logic                   m_sof_o,
    output logic                   m_eol_o,
    output logic [2*DataWidth-1:0] m_data_o,
    output logic                   err_o
);

    typedef enum logic {
        EVEN = 1'b0,
        ODD  = 1'b1
    } state_t;

    state_t                 state_q, state_d;
    logic [DataWidth-1:0]   even_q;
    logic [DataWidth-1:0]   last_odd_q;
    logic                   sof_q;
    logic                   line_has_odd_q;

    logic                   m_valid_q;
    logic                   m_sof_q;
    logic                   m_eol_q;
    logic [2*DataWidth-1:0] m_data_q;
    logic                   err_q;

    logic                   accept;
    logic                   treat_as_even;
    logic                   store_even;
    logic                   load_pair;
    logic                   load_pad;
    logic                   frame_err;
    logic [DataWidth-1:0]   pad_odd;

    // Input is throttled whenever the output register is full and not being drained.
    assign s_ready_o = !m_valid_q || m_ready_i;
    assign accept    = s_valid_i && s_ready_o;

    // A sof beat always starts a new frame, so it is handled as an even sample
    // even when an earlier even sample is still waiting for its partner.
    assign treat_as_even = (state_q == EVEN) || s_sof_i;

    // Pad partner: the last odd sample of this line, or the sample itself for N=1.
    // A sof beat begins a fresh line, so any odd seen before it does not count.
    assign pad_odd = (line_has_odd_q && !s_sof_i) ? last_odd_q : s_data_i;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= EVEN;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (accept) begin
            if (treat_as_even) begin
                state_d = s_eol_i ? EVEN : ODD;
            end else begin
                state_d = EVEN;
            end
        end
    end

    always_comb begin
        store_even = 1'b0;
        load_pair  = 1'b0;
        load_pad   = 1'b0;
        frame_err  = 1'b0;
        if (accept) begin
            frame_err = (state_q == ODD) && s_sof_i;
            if (treat_as_even) begin
                if (s_eol_i) begin
                    load_pad = 1'b1;
                end else begin
                    store_even = 1'b1;
                end
            end else begin
                load_pair = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            even_q         <= '0;
            last_odd_q     <= '0;
            sof_q          <= 1'b0;
            line_has_odd_q <= 1'b0;
            m_valid_q      <= 1'b0;
            m_sof_q        <= 1'b0;
            m_eol_q        <= 1'b0;
            m_data_q       <= '0;
            err_q          <= 1'b0;
        end else begin
            err_q <= frame_err;
            if (store_even) begin
                even_q <= s_data_i;
                sof_q  <= s_sof_i;
            end
            // A load may coincide with a take; the reload wins and valid stays high.
            if (load_pair) begin
                m_valid_q      <= 1'b1;
                m_data_q       <= {s_data_i, even_q};
                m_sof_q        <= sof_q;
                m_eol_q        <= s_eol_i;
                last_odd_q     <= s_data_i;
                line_has_odd_q <= !s_eol_i;
            end else if (load_pad) begin
                m_valid_q      <= 1'b1;
                m_data_q       <= {pad_odd, s_data_i};
                m_sof_q        <= s_sof_i;
                m_eol_q        <= 1'b1;
                line_has_odd_q <= 1'b0;
            end else if (m_ready_i) begin
                m_valid_q <= 1'b0;
            end
        end
    end

    assign m_valid_o = m_valid_q;
    assign m_sof_o   = m_sof_q;
    assign m_eol_o   = m_eol_q;
    assign m_data_o  = m_data_q;
    assign err_o     = err_q;

endmodule

// File: tb/tb_sample_pair_packer.sv
// tb/tb_sample_pair_packer.sv - randomized self-checking bench for sample_pair_packer
module tb_sample_pair_packer;

    logic        clk = 1'b0;
    logic        rst_i;
    logic        s_ready_o;
    logic        s_valid_i;
    logic        s_sof_i;
    logic        s_eol_i;
    logic [15:0] s_data_i;
    logic        m_ready_i;
    logic        m_valid_o;
    logic        m_sof_o;
    logic        m_eol_o;
    logic [31:0] m_data_o;
    logic        err_o;

    always #5 clk = ~clk;

    sample_pair_packer #(.DataWidth(16)) dut (
        .clk_i     (clk),
        .rst_i     (rst_i),
        .s_ready_o (s_ready_o),
        .s_valid_i (s_valid_i),
        .s_sof_i   (s_sof_i),
        .s_eol_i   (s_eol_i),
        .s_data_i  (s_data_i),
        .m_ready_i (m_ready_i),
        .m_valid_o (m_valid_o),
        .m_sof_o   (m_sof_o),
        .m_eol_o   (m_eol_o),
        .m_data_o  (m_data_o),
        .err_o     (err_o)
    );

    typedef struct packed {
        logic [15:0] d;
        logic        sof;
        logic        eol;
    } beat_t;

    typedef struct packed {
        logic [31:0] d;
        logic        sof;
        logic        eol;
    } pair_t;

    beat_t       in_q[$];
    pair_t       exp_q[$];
    logic [15:0] lbuf[0:15];
    int          n_chk = 0;
    int          n_fail = 0;
    int          ready_mode = 0;
    bit          gap_en = 1'b0;
    int          err_cnt = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic push_beat(input logic [15:0] d, input bit sof, input bit eol);
        beat_t b;
        b.d = d;
        b.sof = sof;
        b.eol = eol;
        in_q.push_back(b);
    endtask

    // Reference: a line x[0..n-1] becomes pairs {x[2k+1], x[2k]}; an odd line ends with
    // {x[n-2], x[n-1]} (or {x[0], x[0]} when n==1). sof marks the frame's first pair.
    task automatic add_line(input int n, input bit sof);
        pair_t p;
        for (int i = 0; i < n; i++) push_beat(lbuf[i], sof && (i == 0), i == n - 1);
        for (int k = 0; k < n / 2; k++) begin
            p.d   = {lbuf[2*k+1], lbuf[2*k]};
            p.sof = sof && (k == 0);
            p.eol = (n % 2 == 0) && (k == n / 2 - 1);
            exp_q.push_back(p);
        end
        if (n % 2 == 1) begin
            if (n == 1) p.d = {lbuf[0], lbuf[0]};
            else        p.d = {lbuf[n-2], lbuf[n-1]};
            p.sof = sof && (n == 1);
            p.eol = 1'b1;
            exp_q.push_back(p);
        end
    endtask

    task automatic drain(input string name, input int budget);
        int c = 0;
        while ((in_q.size() != 0 || exp_q.size() != 0) && c < budget) begin
            @(negedge clk);
            c++;
        end
        chk({name, "_drain"}, 64'(in_q.size() + exp_q.size()), 64'd0);
        repeat (2) @(negedge clk);
    endtask

    task automatic wait_in_empty(input string name, input int budget);
        int c = 0;
        while (in_q.size() != 0 && c < budget) begin
            @(negedge clk);
            c++;
        end
        chk({name, "_accepted"}, 64'(in_q.size()), 64'd0);
        repeat (2) @(negedge clk);
    endtask

    task automatic reset_pulse(input string name);
        @(posedge clk);
        #1 rst_i = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst_i = 1'b0;
        exp_q.delete();
        in_q.delete();
        @(negedge clk);
        chk({name, "_valid_after_reset"}, 64'(m_valid_o), 64'd0);
    endtask

    // Driver: decides acceptance at the negedge, changes inputs just after the posedge.
    bit drv_acc;
    always begin
        @(negedge clk);
        drv_acc = s_valid_i && s_ready_o && !rst_i;
        @(posedge clk);
        #1;
        if (drv_acc && in_q.size() != 0) in_q.pop_front();
        case (ready_mode)
            0:       m_ready_i = 1'b1;
            2:       m_ready_i = 1'b0;
            default: m_ready_i = ($urandom_range(0, 3) != 0);
        endcase
        if (in_q.size() != 0 && (!gap_en || $urandom_range(0, 3) != 0)) begin
            s_valid_i = 1'b1;
            s_data_i  = in_q[0].d;
            s_sof_i   = in_q[0].sof;
            s_eol_i   = in_q[0].eol;
        end else begin
            s_valid_i = 1'b0;
            s_data_i  = 16'($urandom);
            s_sof_i   = 1'($urandom);
            s_eol_i   = 1'($urandom);
        end
    end

    // Compare process: every cycle between edges.
    bit          held = 1'b0;
    bit          err_exp = 1'b0;
    bit          comp_exp = 1'b0;
    bit          prev_stall = 1'b0;
    bit          rst_prev = 1'b0;
    bit          mon_acc;
    logic [34:0] snap;
    always @(negedge clk) begin
        if (rst_i) begin
            if (rst_prev)
                chk("reset_outputs", 64'({m_valid_o, m_sof_o, m_eol_o, m_data_o, err_o}), 64'd0);
            rst_prev   = 1'b1;
            held       = 1'b0;
            err_exp    = 1'b0;
            comp_exp   = 1'b0;
            prev_stall = 1'b0;
        end else begin
            rst_prev = 1'b0;
            chk("err_o", 64'(err_o), 64'(err_exp));
            if (err_o) err_cnt++;
            if (comp_exp) chk("latency_valid", 64'(m_valid_o), 64'd1);
            chk("s_ready_o", 64'(s_ready_o), 64'(!m_valid_o || m_ready_i));
            if (prev_stall)
                chk("stall_hold", 64'({m_valid_o, m_sof_o, m_eol_o, m_data_o}), 64'(snap));
            if (m_valid_o && m_ready_i) begin
                if (exp_q.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL unexpected_beat: got %h sof=%0d eol=%0d expected none",
                             m_data_o, m_sof_o, m_eol_o);
                end else begin
                    chk("pair", 64'({m_data_o, m_sof_o, m_eol_o}), 64'(exp_q[0]));
                    exp_q.pop_front();
                end
            end
            prev_stall = m_valid_o && !m_ready_i;
            snap       = {m_valid_o, m_sof_o, m_eol_o, m_data_o};
            // Sample-count view: a held even sample completes on a non-sof beat; eol always completes.
            mon_acc  = s_valid_i && s_ready_o;
            err_exp  = mon_acc && held && s_sof_i;
            comp_exp = mon_acc && (s_eol_i || (held && !s_sof_i));
            if (mon_acc) held = !comp_exp;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int e0;
        rst_i     = 1'b1;
        s_valid_i = 1'b0;
        s_sof_i   = 1'b0;
        s_eol_i   = 1'b0;
        s_data_i  = 16'd0;
        m_ready_i = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst_i = 1'b0;
        @(negedge clk);

        // Even-length line 0,1,2,3
        for (int i = 0; i < 4; i++) lbuf[i] = 16'(i);
        add_line(4, 1'b1);
        chk("model_t1_p0", 64'(exp_q[0]), 64'({32'h0001_0000, 1'b1, 1'b0}));
        chk("model_t1_p1", 64'(exp_q[1]), 64'({32'h0003_0002, 1'b0, 1'b1}));
        drain("even_line", 50);

        // Odd-length line 10..50
        for (int i = 0; i < 5; i++) lbuf[i] = 16'(10 * (i + 1));
        add_line(5, 1'b1);
        chk("model_t2_p0", 64'(exp_q[0]), 64'({32'h0014_000A, 1'b1, 1'b0}));
        chk("model_t2_pad", 64'(exp_q[2]), 64'({32'h0028_0032, 1'b0, 1'b1}));
        drain("odd_line", 50);

        // Single-sample line
        lbuf[0] = 16'd7;
        add_line(1, 1'b1);
        chk("model_t3_pad", 64'(exp_q[0]), 64'({32'h0007_0007, 1'b1, 1'b1}));
        drain("single", 50);

        // Backpressure
        ready_mode = 2;
        lbuf[0] = 16'h11; lbuf[1] = 16'h22; lbuf[2] = 16'h33; lbuf[3] = 16'h44;
        add_line(4, 1'b1);
        repeat (6) @(negedge clk);
        chk("bp_s_ready", 64'(s_ready_o), 64'd0);
        chk("bp_m_valid", 64'(m_valid_o), 64'd1);
        chk("bp_m_data", 64'(m_data_o), 64'h0022_0011);
        chk("bp_pending_inputs", 64'(in_q.size()), 64'd2);
        ready_mode = 0;
        drain("backpressure", 50);

        // Framing violation: 5(sof), 6(sof), 9(eol)
        e0 = err_cnt;
        push_beat(16'd5, 1'b1, 1'b0);
        push_beat(16'd6, 1'b1, 1'b0);
        push_beat(16'd9, 1'b0, 1'b1);
        begin
            pair_t p;
            p.d = 32'h0009_0006; p.sof = 1'b1; p.eol = 1'b1;
            exp_q.push_back(p);
        end
        drain("violation", 50);
        chk("violation_err_pulses", 64'(err_cnt - e0), 64'd1);

        // Reset with an even sample held
        lbuf[0] = 16'hA1; lbuf[1] = 16'hA2; lbuf[2] = 16'hA3;
        add_line(2, 1'b1);
        push_beat(16'hA3, 1'b0, 1'b0);
        drain("pre_reset", 50);
        reset_pulse("held_even");
        lbuf[0] = 16'd2; lbuf[1] = 16'd3;
        add_line(2, 1'b1);
        chk("model_t6", 64'(exp_q[0]), 64'({32'h0003_0002, 1'b1, 1'b1}));
        drain("after_reset1", 50);

        // Reset with an output beat pending
        ready_mode = 2;
        push_beat(16'hB1, 1'b1, 1'b0);
        push_beat(16'hB2, 1'b0, 1'b0);
        wait_in_empty("pending", 50);
        reset_pulse("pending_out");
        ready_mode = 0;
        lbuf[0] = 16'd2; lbuf[1] = 16'd3;
        add_line(2, 1'b1);
        drain("after_reset2", 50);

        // Randomized frames with random gaps and backpressure
        ready_mode = 1;
        gap_en = 1'b1;
        for (int l = 0; l < 40; l++) begin
            int n;
            n = $urandom_range(1, 9);
            for (int i = 0; i < n; i++) lbuf[i] = 16'($urandom);
            add_line(n, (l % 4) == 0);
        end
        drain("random", 5000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
